// File: rtl/lc3b_types.sv
// rtl/lc3b_types.sv - LC-3b word/line types and L2 port scheduler enums
package lc3b_types;

  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_c_line;

  typedef enum logic [2:0] {
    IDLE,
    BUSY_I,
    BUSY_D,
    RESP_I,
    RESP_D
  } arb_state_t;

  typedef enum logic {
    SRC_I,
    SRC_D
  } arb_src_t;

endpackage

// File: rtl/arb_starve_ctr.sv
// rtl/arb_starve_ctr.sv - saturating contested-win counter with clear and at-limit flag
module arb_starve_ctr #(
  parameter int LIMIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_inc,
  input  logic i_clr,
  output logic o_at_limit
);

  localparam int W = $clog2(LIMIT + 1);
  localparam logic [W-1:0] MAX = W'(LIMIT);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != MAX)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_at_limit = (r_cnt == MAX);

endmodule

// File: rtl/mem_port_sched.sv
// rtl/mem_port_sched.sv - registered i/d-cache scheduler for the shared L2 port
// ARB_STARVE_GUARD_EN compiles in the i-cache anti-starvation guard.
module mem_port_sched
  import lc3b_types::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [15:0]  imem_address,
  input  logic         imem_read,
  input  logic         imem_write,
  input  logic [127:0] imem_wdata,
  output logic [127:0] imem_rdata,
  output logic         imem_resp,
  input  logic [15:0]  dmem_address,
  input  logic         dmem_read,
  input  logic         dmem_write,
  input  logic [127:0] dmem_wdata,
  output logic [127:0] dmem_rdata,
  output logic         dmem_resp,
  output logic [15:0]  L2_mem_address,
  output logic         L2_mem_read,
  output logic         L2_mem_write,
  output logic [127:0] L2_mem_wdata,
  input  logic         L2_mem_resp,
  input  logic [127:0] L2_mem_rdata
);

  arb_state_t r_state;
  lc3b_word   r_addr;
  lc3b_c_line r_wdata;
  lc3b_c_line r_line;
  logic       r_l2_rd;
  logic       r_l2_wr;
  logic       r_iresp;
  logic       r_dresp;

  logic       w_i_pend;
  logic       w_d_pend;
  logic       w_force_i;
  logic       w_grant;
  arb_src_t   w_src;

  assign w_i_pend = imem_read | imem_write;
  assign w_d_pend = dmem_read | dmem_write;
  assign w_grant  = (r_state == IDLE) && (w_i_pend || w_d_pend);
  assign w_src    = (w_d_pend && !(w_i_pend && w_force_i)) ? SRC_D : SRC_I;

`ifdef ARB_STARVE_GUARD_EN
  logic w_at_limit;

  arb_starve_ctr #(
    .LIMIT (STARVE_LIMIT)
  ) u_starve (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_inc      (w_grant && (w_src == SRC_D) && w_i_pend),
    .i_clr      (w_grant && (w_src == SRC_I)),
    .o_at_limit (w_at_limit)
  );

  assign w_force_i = w_at_limit;
`else
  assign w_force_i = 1'b0;
`endif

  // A simultaneous read+write from one cache is treated as a write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_addr  <= '0;
      r_wdata <= '0;
      r_line  <= '0;
      r_l2_rd <= 1'b0;
      r_l2_wr <= 1'b0;
      r_iresp <= 1'b0;
      r_dresp <= 1'b0;
    end else begin
      r_iresp <= 1'b0;
      r_dresp <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_grant) begin
            if (w_src == SRC_D) begin
              r_addr  <= dmem_address;
              r_wdata <= dmem_wdata;
              r_l2_wr <= dmem_write;
              r_l2_rd <= dmem_read & ~dmem_write;
              r_state <= BUSY_D;
            end else begin
              r_addr  <= imem_address;
              r_wdata <= imem_wdata;
              r_l2_wr <= imem_write;
              r_l2_rd <= imem_read & ~imem_write;
              r_state <= BUSY_I;
            end
          end
        end
        BUSY_I, BUSY_D: begin
          if (L2_mem_resp) begin
            r_line  <= L2_mem_rdata;
            r_l2_rd <= 1'b0;
            r_l2_wr <= 1'b0;
            r_iresp <= (r_state == BUSY_I);
            r_dresp <= (r_state == BUSY_D);
            r_state <= (r_state == BUSY_I) ? RESP_I : RESP_D;
          end
        end
        RESP_I, RESP_D: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign L2_mem_address = r_addr;
  assign L2_mem_wdata   = r_wdata;
  assign L2_mem_read    = r_l2_rd;
  assign L2_mem_write   = r_l2_wr;
  assign imem_resp      = r_iresp;
  assign dmem_resp      = r_dresp;
  assign imem_rdata     = r_line;
  assign dmem_rdata     = r_line;

endmodule
